// File: rtl/interleaved_mod_mult.sv
// Bit-serial interleaved modular multiplier: (a*b) mod n, one multiplier bit per cycle, MSB first.
// Start/finished responder for the ECC point-arithmetic sequencers.
module interleaved_mod_mult #(
  parameter int unsigned WIDTH   = 256,
  parameter logic [1:0]  BITS256 = 2'd0,
  parameter logic [1:0]  BITS128 = 2'd1,
  parameter logic [1:0]  BITS64  = 2'd2,
  parameter logic [1:0]  BITS32  = 2'd3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_busy
);

  // Two guard bits so 2*acc + a never overflows.
  localparam int unsigned AccW = WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             finished_q, finished_d;

  logic [8:0]       k;
  logic [WIDTH-1:0] mask;
  logic [AccW-1:0]  n_ext;
  logic [AccW-1:0]  dbl;
  logic [AccW-1:0]  dbl_red;
  logic [AccW-1:0]  sum;
  logic [AccW-1:0]  sum_red;

  always_comb begin
    k = 9'd256;
    case (i_mode)
      BITS32:  k = 9'd32;
      BITS64:  k = 9'd64;
      BITS128: k = 9'd128;
      BITS256: k = 9'd256;
      default: k = 9'd256;
    endcase
    mask = {WIDTH{1'b1}} >> (WIDTH - 32'(k));
  end

  // One interleaved step: double-and-reduce, then conditional add-and-reduce.
  always_comb begin
    n_ext   = {2'b00, n_q};
    dbl     = acc_q << 1;
    dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
    sum     = dbl_red + (b_q[cnt_q] ? {2'b00, a_q} : {AccW{1'b0}});
    sum_red = (sum >= n_ext) ? sum - n_ext : sum;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    n_d        = n_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    finished_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          a_d     = i_a & mask;
          b_d     = i_b & mask;
          n_d     = i_n & mask;
          acc_d   = '0;
          cnt_d   = 8'(k - 9'd1);
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = sum_red;
        if (cnt_q == 8'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        result_d   = acc_q[WIDTH-1:0];
        finished_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      finished_q <= finished_d;
    end
  end

  assign o_result   = result_q;
  assign o_finished = finished_q;
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_interleaved_mod_mult.sv
// Self-checking bench for interleaved_mod_mult: directed and random products against a
// wide-arithmetic (a*b) % n reference, plus handshake timing, busy-start and reset abort.
module tb_interleaved_mod_mult;

  localparam int W = 256;
  localparam logic [1:0] M256 = 2'd0;
  localparam logic [1:0] M128 = 2'd1;
  localparam logic [1:0] M64  = 2'd2;
  localparam logic [1:0] M32  = 2'd3;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_start = 1'b0;
  logic [1:0]   i_mode = M32;
  logic [W-1:0] i_n = '0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic [W-1:0] o_result;
  logic         o_finished;
  logic         o_busy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_res = '0;

  interleaved_mod_mult #(
    .WIDTH  (W),
    .BITS256(M256),
    .BITS128(M128),
    .BITS64 (M64),
    .BITS32 (M32)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_mode    (i_mode),
    .i_n       (i_n),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_result  (o_result),
    .o_finished(o_finished),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic int mode_k(input logic [1:0] m);
    case (m)
      M32:     return 32;
      M64:     return 64;
      M128:    return 128;
      default: return 256;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: truncate operands to k bits, full-width product, remainder.
  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] n, input int k);
    logic [W-1:0]   m;
    logic [2*W-1:0] p;
    logic [2*W-1:0] r;
    m = (k >= W) ? {W{1'b1}} : ((W'(1) << k) - W'(1));
    p = {{W{1'b0}}, a & m} * {{W{1'b0}}, b & m};
    r = p % {{W{1'b0}}, n & m};
    return r[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle, then scramble every input to prove only captured copies matter.
  task automatic start_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] n);
    @(negedge i_clk);
    i_mode  = m;
    i_a     = a;
    i_b     = b;
    i_n     = n;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_a     = rnd256();
    i_b     = rnd256();
    i_n     = rnd256();
    i_mode  = 2'($urandom);
  endtask

  // Called right after start_op; poke1/poke2 are edges at which a stray start is driven.
  task automatic finish_op(input string tag, input int k, input logic [W-1:0] exp,
                           input int poke1, input int poke2);
    int cyc = 0;
    int busy_cnt = 0;
    bit done = 1'b0;
    check({tag, "/fin_low_after_start"}, W'(o_finished), W'(0));
    if (o_busy) busy_cnt++;
    while (!done && cyc < 400) begin
      @(negedge i_clk);
      i_start = (cyc + 1 == poke1) || (cyc + 1 == poke2);
      if (i_start) begin
        i_a = rnd256();
        i_b = rnd256();
        i_n = rnd256();
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      cyc++;
      if (o_finished) begin
        done = 1'b1;
      end else begin
        if (o_busy) busy_cnt++;
        if (cyc == k / 2) check({tag, "/result_held"}, o_result, last_res);
      end
    end
    check({tag, "/latency"}, W'(cyc), W'(k + 1));
    check({tag, "/result"}, o_result, exp);
    check({tag, "/busy_cycles"}, W'(busy_cnt), W'(k + 1));
    check({tag, "/idle_at_finish"}, W'(o_busy), W'(0));
    last_res = exp;
  endtask

  initial begin
    logic [W-1:0] n, a, b, e;
    logic [1:0]   m;

    // Reset state, both during and just after reset.
    #1;
    check("rst/result", o_result, '0);
    check("rst/finished", W'(o_finished), W'(0));
    check("rst/busy", W'(o_busy), W'(0));
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("post_rst/busy", W'(o_busy), W'(0));
    check("post_rst/finished", W'(o_finished), W'(0));

    start_op(M32, W'(7), W'(9), W'(11));
    finish_op("b32_small", 32, W'(8), 0, 0);
    @(posedge i_clk);
    #1;
    check("b32_small/fin_one_cycle", W'(o_finished), W'(0));
    check("b32_small/result_kept", o_result, W'(8));

    n = (W'(1) << 255) - W'(19);
    start_op(M256, n - W'(1), n - W'(1), n);
    finish_op("b256_nm1_sq", 256, W'(1), 0, 0);
    start_op(M256, n - W'(1), W'(0), n);
    finish_op("b256_b0", 256, W'(0), 0, 0);

    // a = n-1 == -1 (mod n), so the product is n-3; upper garbage must be ignored.
    a = rnd256();
    b = rnd256();
    n = rnd256();
    a[63:0] = 64'hFFFF_FFFF_FFFF_FFFE;
    b[63:0] = 64'd3;
    n[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    start_op(M64, a, b, n);
    finish_op("b64_garbage", 64, W'(64'hFFFF_FFFF_FFFF_FFFC), 0, 0);

    for (int i = 0; i < 4; i++) begin
      m = (i < 2) ? M128 : ((i == 2) ? M64 : M32);
      n = rnd256() & ((W'(1) << mode_k(m)) - W'(1));
      n[1] = 1'b1;
      a = rnd256() % n;
      b = rnd256();
      e = ref_mod(a, b, n, mode_k(m));
      start_op(m, a, b, n);
      finish_op($sformatf("rand%0d", i), mode_k(m), e, 0, 0);
    end

    // Starts while busy are dropped; a start right after finished is accepted.
    start_op(M32, W'(5), W'(6), W'(13));
    finish_op("busy_start", 32, W'(4), 5, 20);
    a = W'(100);
    b = W'(200);
    n = W'(211);
    start_op(M32, a, b, n);
    finish_op("back2back", 32, ref_mod(a, b, n, 32), 0, 0);

    // Asynchronous abort mid-operation.
    n = rnd256();
    n[255] = 1'b1;
    a = rnd256() % n;
    b = rnd256();
    start_op(M256, a, b, n);
    repeat (9) @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    check("abort/result", o_result, '0);
    check("abort/finished", W'(o_finished), W'(0));
    check("abort/busy", W'(o_busy), W'(0));
    last_res = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("abort/no_pulse", W'(o_finished), W'(0));
    check("abort/idle", W'(o_busy), W'(0));
    start_op(M256, a, b, n);
    finish_op("after_abort", 256, ref_mod(a, b, n, 256), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
